i2s_tx_master_sequencer: RTL and testbench

- I2S transmit-master controller: accepts left/right sample frames over a valid/ready handshake and generates sclk, ws and sd.
- Emits MSB-first serial data with the standard one-bit ws-to-data delay.
- Supports stereo and mono framing, and 8/16/24/32-bit slot widths selected per frame.
- Sits between the host sample source and the I2S pins (sclk/ws/sd) of a transmit-master channel.
- A one-entry holding buffer allows gapless back-to-back frames.

---
 rtl/i2s_tx_master_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_i2s_tx_master_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module : i2s_tx_master_sequencer
// I2S transmit master: one-frame holding buffer feeding an MSB-first serialiser.
// Rev    : 1.0
// ============================================================================
module i2s_tx_master_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAXIMUM_SIZE = 4,
  parameter int SCLK_HALF    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_valid_i,
  output logic                                 frame_ready_o,
  input  logic [DATA_WIDTH*MAXIMUM_SIZE-1:0]   left_i,
  input  logic [DATA_WIDTH*MAXIMUM_SIZE-1:0]   right_i,
  input  logic [1:0]                           num_bits_i,
  input  logic                                 mono_i,
  output logic                                 sclk_o,
  output logic                                 ws_o,
  output logic                                 sd_o,
  output logic [2:0]                           state_o,
  output logic                                 frame_done_o,
  output logic                                 underrun_o
);

  localparam int W  = DATA_WIDTH * MAXIMUM_SIZE;
  localparam int CW = $clog2(2 * W + 2);
  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  localparam logic [2:0] S_RST_DEACT = 3'd0;
  localparam logic [2:0] S_RST_ACT   = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_LEFT      = 3'd3;
  localparam logic [2:0] S_RIGHT     = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          buf_full_q, buf_full_d;
  logic [W-1:0]  buf_left_q, buf_left_d, buf_right_q, buf_right_d;
  logic [1:0]    buf_code_q, buf_code_d;
  logic          buf_mono_q, buf_mono_d;
  logic [W-1:0]  sh_left_q, sh_left_d, sh_right_q, sh_right_d;
  logic [1:0]    code_q, code_d;
  logic [CW-1:0] fall_q, fall_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d, ws_q, ws_d, sd_q, sd_d;
  logic          done_q, done_d, und_q, und_d;

  logic          w_active, w_tick, w_fall, w_start;
  logic [CW-1:0] w_n, w_2n, w_k;
  logic [W-1:0]  w_left_al, w_right_al;

  // Move the N used bits of a sample to the top so the shifter always emits bit W-1.
  function automatic logic [W-1:0] align_msb(input logic [W-1:0] d, input logic [1:0] code);
    logic [W-1:0] r;
    case (code)
      2'd0:    r = d << (W - 8);
      2'd1:    r = d << (W - 16);
      2'd2:    r = d << (W - 24);
      default: r = d << (W - 32);
    endcase
    return r;
  endfunction

  assign w_active   = (state_q == S_LEFT) || (state_q == S_RIGHT);
  assign w_tick     = w_active && (cnt_q == HW'(SCLK_HALF - 1));
  assign w_fall     = w_tick && sclk_q;
  assign w_start    = (state_q == S_IDLE) && buf_full_q;
  assign w_n        = CW'({code_q, 3'b000}) + CW'(8);
  assign w_2n       = w_n << 1;
  assign w_k        = fall_q + CW'(1);
  assign w_left_al  = align_msb(buf_left_q, buf_code_q);
  assign w_right_al = buf_mono_q ? '0 : align_msb(buf_right_q, buf_code_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RST_ACT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST_ACT:   state_d = S_RST_DEACT;
      S_RST_DEACT: state_d = S_IDLE;
      S_IDLE:      if (buf_full_q) state_d = S_LEFT;
      S_LEFT:      if (w_fall && (w_k == w_n + CW'(1))) state_d = S_RIGHT;
      S_RIGHT:     if (w_fall && (w_k == w_2n + CW'(1))) state_d = buf_full_q ? S_LEFT : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    frame_ready_o = ~buf_full_q && (state_q != S_RST_ACT) && (state_q != S_RST_DEACT);
    state_o       = state_q;
  end

  always_comb begin
    buf_full_d  = buf_full_q;
    buf_left_d  = buf_left_q;
    buf_right_d = buf_right_q;
    buf_code_d  = buf_code_q;
    buf_mono_d  = buf_mono_q;
    sh_left_d   = sh_left_q;
    sh_right_d  = sh_right_q;
    code_d      = code_q;
    fall_d      = fall_q;
    cnt_d       = cnt_q;
    sclk_d      = sclk_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    done_d      = 1'b0;
    und_d       = 1'b0;
    if (w_start) begin
      sh_left_d  = w_left_al;
      sh_right_d = w_right_al;
      code_d     = buf_code_q;
      buf_full_d = 1'b0;
      fall_d     = '0;
      cnt_d      = '0;
      sclk_d     = 1'b0;
      ws_d       = 1'b0;
      sd_d       = 1'b0;
    end else if (w_active) begin
      if (w_tick) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d  = cnt_q + HW'(1);
      end
      if (w_fall) begin
        fall_d = w_k;
        if (w_k <= w_n) begin
          sd_d      = sh_left_q[W-1];
          sh_left_d = sh_left_q << 1;
          if (w_k == w_n) ws_d = 1'b1;
        end else if (w_k <= w_2n) begin
          sd_d       = sh_right_q[W-1];
          sh_right_d = sh_right_q << 1;
          if (w_k == w_2n) begin
            ws_d   = 1'b0;
            done_d = 1'b1;
          end
        end else if (buf_full_q) begin
          // Gapless hand-over: this fall is already fall 1 of the next frame.
          sd_d       = w_left_al[W-1];
          sh_left_d  = w_left_al << 1;
          sh_right_d = w_right_al;
          code_d     = buf_code_q;
          buf_full_d = 1'b0;
          fall_d     = CW'(1);
        end else begin
          sd_d   = 1'b0;
          cnt_d  = '0;
          fall_d = '0;
          und_d  = 1'b1;
        end
      end
    end
    if (frame_valid_i && frame_ready_o) begin
      buf_full_d  = 1'b1;
      buf_left_d  = left_i;
      buf_right_d = right_i;
      buf_code_d  = num_bits_i;
      buf_mono_d  = mono_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_q  <= 1'b0;
      buf_left_q  <= '0;
      buf_right_q <= '0;
      buf_code_q  <= '0;
      buf_mono_q  <= 1'b0;
      sh_left_q   <= '0;
      sh_right_q  <= '0;
      code_q      <= '0;
      fall_q      <= '0;
      cnt_q       <= '0;
      sclk_q      <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      done_q      <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_left_q  <= buf_left_d;
      buf_right_q <= buf_right_d;
      buf_code_q  <= buf_code_d;
      buf_mono_q  <= buf_mono_d;
      sh_left_q   <= sh_left_d;
      sh_right_q  <= sh_right_d;
      code_q      <= code_d;
      fall_q      <= fall_d;
      cnt_q       <= cnt_d;
      sclk_q      <= sclk_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      done_q      <= done_d;
      und_q       <= und_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign ws_o         = ws_q;
  assign sd_o         = sd_q;
  assign frame_done_o = done_q;
  assign underrun_o   = und_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_i2s_tx_master_sequencer
// Drives two sequencers (SCLK_HALF 2 and 1) with random frames against a timing model.
// Rev    : 1.0
// ============================================================================
module tb_i2s_tx_master_sequencer;

  localparam int W = 32;
  localparam int HALF [2] = '{2, 1};

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   valid, ready, sclk, ws, sd, done, und;
  logic [W-1:0] left, right;
  logic [1:0]   nb;
  logic         mono;
  logic [2:0]   st0, st1;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: each frame is a start edge S; fall k lands on edge S + 2*H*k.
  int           m_t;
  int           m_S [2], m_post [2], m_N [2], m_bN [2];
  bit           m_act [2], m_mono [2], m_bf [2], m_bm [2], m_rdy [2], acc [2];
  logic [W-1:0] m_l [2], m_r [2], m_bl [2], m_br [2];
  bit           e_sd [2], e_ws [2], e_done [2], e_und [2];

  always #5 clk = ~clk;

  i2s_tx_master_sequencer #(.DATA_WIDTH(8), .MAXIMUM_SIZE(4), .SCLK_HALF(2)) u_dut0 (
    .clk(clk), .rst(rst), .frame_valid_i(valid[0]), .frame_ready_o(ready[0]),
    .left_i(left), .right_i(right), .num_bits_i(nb), .mono_i(mono),
    .sclk_o(sclk[0]), .ws_o(ws[0]), .sd_o(sd[0]), .state_o(st0),
    .frame_done_o(done[0]), .underrun_o(und[0]));

  i2s_tx_master_sequencer #(.DATA_WIDTH(8), .MAXIMUM_SIZE(4), .SCLK_HALF(1)) u_dut1 (
    .clk(clk), .rst(rst), .frame_valid_i(valid[1]), .frame_ready_o(ready[1]),
    .left_i(left), .right_i(right), .num_bits_i(nb), .mono_i(mono),
    .sclk_o(sclk[1]), .ws_o(ws[1]), .sd_o(sd[1]), .state_o(st1),
    .frame_done_o(done[1]), .underrun_o(und[1]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset(input int u);
    m_post[u] = 0; m_act[u] = 0; m_bf[u] = 0; m_rdy[u] = 0;
    e_sd[u] = 0; e_ws[u] = 0; e_done[u] = 0; e_und[u] = 0;
  endtask

  task automatic model_load(input int u);
    m_l[u] = m_bl[u]; m_r[u] = m_br[u]; m_N[u] = m_bN[u]; m_mono[u] = m_bm[u];
    m_bf[u] = 0;
  endtask

  task automatic model_step(input int u);
    int h, d, k;
    h = HALF[u];
    acc[u] = valid[u] && m_rdy[u];
    e_done[u] = 0;
    e_und[u]  = 0;
    if (rst) begin
      model_reset(u);
      return;
    end
    if (m_post[u] < 2) begin
      m_post[u]++;
    end else begin
      if (m_act[u]) begin
        d = m_t - m_S[u];
        if (d % (2 * h) == 0) begin
          k = d / (2 * h);
          if (k <= m_N[u]) begin
            e_sd[u] = m_l[u][m_N[u] - k];
            e_ws[u] = (k == m_N[u]);
          end else if (k <= 2 * m_N[u]) begin
            e_sd[u]   = m_mono[u] ? 1'b0 : m_r[u][2 * m_N[u] - k];
            e_ws[u]   = (k < 2 * m_N[u]);
            e_done[u] = (k == 2 * m_N[u]);
          end else if (m_bf[u]) begin
            model_load(u);
            m_S[u]  = m_t - 2 * h;
            e_sd[u] = m_l[u][m_N[u] - 1];
            e_ws[u] = 0;
          end else begin
            m_act[u] = 0; e_sd[u] = 0; e_ws[u] = 0; e_und[u] = 1;
          end
        end
      end else if (m_bf[u]) begin
        model_load(u);
        m_S[u] = m_t; m_act[u] = 1; e_sd[u] = 0; e_ws[u] = 0;
      end
      if (acc[u]) begin
        m_bf[u] = 1; m_bl[u] = left; m_br[u] = right;
        m_bN[u] = 8 * (int'(nb) + 1); m_bm[u] = mono;
      end
    end
    m_rdy[u] = (m_post[u] == 2) && !m_bf[u];
  endtask

  task automatic compare_all();
    int h, exp_st, exp_sclk;
    logic [2:0] st;
    for (int u = 0; u < 2; u++) begin
      h = HALF[u];
      st = (u == 0) ? st0 : st1;
      exp_sclk = m_act[u] ? ((m_t - m_S[u]) / h) % 2 : 0;
      if (m_post[u] == 0)      exp_st = 1;
      else if (m_post[u] == 1) exp_st = 0;
      else if (!m_act[u])      exp_st = 2;
      else                     exp_st = ((m_t - m_S[u]) >= 2 * h * (m_N[u] + 1)) ? 4 : 3;
      check_eq($sformatf("u%0d sclk", u),  32'(sclk[u]),  32'(exp_sclk));
      check_eq($sformatf("u%0d ws", u),    32'(ws[u]),    32'(e_ws[u]));
      check_eq($sformatf("u%0d sd", u),    32'(sd[u]),    32'(e_sd[u]));
      check_eq($sformatf("u%0d ready", u), 32'(ready[u]), 32'(m_rdy[u]));
      check_eq($sformatf("u%0d state", u), 32'(st),       32'(exp_st));
      check_eq($sformatf("u%0d done", u),  32'(done[u]),  32'(e_done[u]));
      check_eq($sformatf("u%0d underrun", u), 32'(und[u]), 32'(e_und[u]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_t++;
    for (int u = 0; u < 2; u++) model_step(u);
    @(negedge clk);
    compare_all();
    for (int u = 0; u < 2; u++) if (acc[u]) valid[u] = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r,
                       input logic [1:0] c, input logic m, input bit jitter);
    int guard;
    guard = 0;
    left = l; right = r; nb = c; mono = m; valid = 2'b11;
    while (valid != 2'b00 && guard < 3000) begin
      tick();
      guard++;
      if (jitter && valid != 2'b00) begin
        left = $urandom; right = $urandom; nb = 2'($urandom); mono = 1'($urandom);
      end
    end
    if (valid != 2'b00) begin
      check_eq("accept_timeout", 32'(valid), 32'd0);
      valid = 2'b00;
    end
  endtask

  task automatic async_reset(input int hold);
    valid = 2'b00;
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) model_reset(u);
    compare_all();
    run(hold);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, e, gap;
    rst = 1'b1; valid = 2'b00; left = '0; right = '0; nb = 2'd0; mono = 1'b0;
    m_t = 0;
    for (int u = 0; u < 2; u++) begin model_reset(u); m_S[u] = 0; m_N[u] = 8; end
    @(negedge clk);
    compare_all();
    run(2);
    rst = 1'b0;
    run(3);

    offer(32'hA5, 32'h3C, 2'd0, 1'b0, 1'b0);
    run(90);
    offer(32'h8001, 32'hFFFF, 2'd1, 1'b1, 1'b0);
    run(150);
    offer(32'h01, 32'h02, 2'd0, 1'b0, 1'b0);
    offer(32'hDEADBEEF, 32'h12345678, 2'd3, 1'b0, 1'b0);
    run(400);

    // Abort an N=24 frame at its fifth fall.
    offer(32'hABCDEF, 32'h135790, 2'd2, 1'b0, 1'b0);
    guard = 0;
    while (!(m_act[0] && (m_t - m_S[0]) == 20) && guard < 1000) begin tick(); guard++; end
    async_reset(2);
    run(4);

    // Third frame waits on a full buffer while its data keeps changing.
    offer(32'h11, 32'h22, 2'd0, 1'b0, 1'b0);
    offer(32'h33, 32'h44, 2'd0, 1'b0, 1'b0);
    offer(32'h5A5A, 32'hC3C3, 2'd1, 1'b0, 1'b1);
    run(300);

    // Accept landing on the same edge as fall 2N+1 of the unit with SCLK_HALF=2.
    offer(32'h96, 32'h69, 2'd0, 1'b0, 1'b0);
    tick();
    e = m_S[0] + 4 * 17;
    guard = 0;
    while (m_t < e - 1 && guard < 1000) begin tick(); guard++; end
    offer(32'hF0, 32'h0F, 2'd0, 1'b0, 1'b0);
    run(100);

    for (int i = 0; i < 30; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : 0;
      run(gap);
      offer($urandom, $urandom, 2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end
    run(400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
